// File: rtl/buffer_stream_reader_pkg.sv
// Shared definitions for the TensorCore operand-buffer read path:
// default geometry and the reader FSM encoding.
package tc_buf_pkg;

    localparam int TC_DATA_WIDTH = 64;
    localparam int TC_ADDR_WIDTH = 6;
    localparam int TC_CNT_WIDTH  = TC_ADDR_WIDTH + 1;

    typedef logic [1:0] rd_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

endpackage

// File: rtl/buffer_stream_reader_if.sv
// Bundles the buffer read port and the outgoing beat stream seen by the reader.
interface buffer_stream_reader_if
    import tc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = TC_DATA_WIDTH,
    parameter int ADDR_WIDTH = TC_ADDR_WIDTH
);

    logic                  buf_ready;
    logic                  buf_rd_en;
    logic [ADDR_WIDTH-1:0] buf_rd_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        input  buf_ready, buf_data, m_ready,
        output buf_rd_en, buf_rd_addr, m_valid, m_data, m_last
    );

    modport slave (
        output buf_ready, buf_data, m_ready,
        input  buf_rd_en, buf_rd_addr, m_valid, m_data, m_last
    );

endinterface

// File: rtl/buffer_stream_reader_fifo2.sv
// Two-entry synchronous FIFO carrying a data word plus a last-beat flag.
module stream_fifo2 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_last
);

    logic [DATA_WIDTH-1:0] r_data [2];
    logic [1:0]            r_last;
    logic                  r_rdPtr;
    logic                  r_wrPtr;
    logic [1:0]            r_count;
    logic                  w_doPush;
    logic                  w_doPop;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign w_doPop  = i_pop && (r_count != 2'd0);
    assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_rdPtr   <= 1'b0;
            r_wrPtr   <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_data[r_wrPtr] <= i_push_data;
                r_last[r_wrPtr] <= i_push_last;
                r_wrPtr         <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_data[r_rdPtr];
    assign o_head_last = r_last[r_rdPtr];

endmodule

// File: rtl/buffer_stream_reader.sv
// Read-side sequencer: walks a strided address burst through the operand
// buffer and streams the words downstream with a last-beat marker.
module buffer_stream_reader
    import tc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = TC_DATA_WIDTH,
    parameter int ADDR_WIDTH = TC_ADDR_WIDTH,
    parameter int CNT_WIDTH  = TC_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic [CNT_WIDTH-1:0]  i_count,
    output logic                  o_busy,
    output logic                  o_done,
    buffer_stream_reader_if.master bus
);

    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_lastAddr;
    logic [CNT_WIDTH-1:0]  r_remain;
    logic                  r_done;

    logic [1:0]            w_fifoCount;
    logic [DATA_WIDTH-1:0] w_headData;
    logic                  w_headLast;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_finalIssue;
    logic                  w_accept;

    // Reads may refill the slot freed by a same-cycle pop, giving one beat per cycle.
    assign w_pop        = bus.m_valid && bus.m_ready;
    assign w_issue      = (r_state == ST_STREAM) && ((w_fifoCount < 2'd2) || w_pop);
    assign w_finalIssue = w_issue && (r_remain == CNT_WIDTH'(1));
    assign w_accept     = (r_state == ST_IDLE) && i_start && bus.buf_ready;

    assign bus.buf_rd_en   = w_issue;
    assign bus.buf_rd_addr = w_issue ? r_addr : r_lastAddr;
    assign bus.m_valid     = (w_fifoCount != 2'd0);
    assign bus.m_data      = w_headData;
    assign bus.m_last      = w_headLast;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_done          = r_done;

    stream_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_issue),
        .i_push_data (bus.buf_data),
        .i_push_last (w_finalIssue),
        .i_pop       (w_pop),
        .o_count     (w_fifoCount),
        .o_head_data (w_headData),
        .o_head_last (w_headLast)
    );

    // A zero-length command completes immediately without ever leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_stride   <= '0;
            r_lastAddr <= '0;
            r_remain   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (i_count != '0) begin
                            r_addr   <= i_base_addr;
                            r_stride <= i_stride;
                            r_remain <= i_count;
                            r_state  <= ST_STREAM;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_issue) begin
                        r_lastAddr <= r_addr;
                        r_addr     <= r_addr + r_stride;
                        r_remain   <= r_remain - CNT_WIDTH'(1);
                        if (w_finalIssue) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_headLast) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Scoreboard bench for buffer_stream_reader: directed bursts queue their
// expected beats, and a negedge monitor pops and compares each handshake.
module tb_buffer_stream_reader;
    import tc_buf_pkg::*;

    localparam int DW = 64;
    localparam int AW = 6;
    localparam int CW = 7;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] baseAddr = '0;
    logic [AW-1:0] strideVal = '0;
    logic [CW-1:0] countVal = '0;
    logic          busy;
    logic          done;
    logic          mReady = 1'b1;
    logic          bufReady = 1'b1;

    logic [DW-1:0] mem [64];
    beat_t         sbQueue [$];

    int   total = 0;
    int   bad = 0;
    int   cycleCnt = 0;
    int   startCycle = 0;
    int   firstBeatCycle = -1;
    int   doneCycle = -1;
    int   doneCount = 0;
    int   beatCount = 0;
    logic readyPattern = 1'b0;
    int   readyPhase = 0;
    logic zeroCmd = 1'b0;

    logic          expDone = 1'b0;
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevData = '0;
    logic          prevLast = 1'b0;
    int            occ = 0;

    buffer_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    assign bus.buf_data  = mem[bus.buf_rd_addr];
    assign bus.m_ready   = mReady;
    assign bus.buf_ready = bufReady;

    buffer_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_base_addr (baseAddr),
        .i_stride    (strideVal),
        .i_count     (countVal),
        .o_busy      (busy),
        .o_done      (done),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Downstream acceptance: always ready, or a 1,0,0 repeating pattern for backpressure.
    always @(posedge clk) begin
        #1;
        if (readyPattern) begin
            mReady = ((readyPhase % 3) == 0);
            readyPhase++;
        end else begin
            mReady = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] s,
                                 input logic [CW-1:0] n, input logic expectBeats);
        logic [AW-1:0] a;
        start      = 1'b1;
        baseAddr   = b;
        strideVal  = s;
        countVal   = n;
        startCycle = cycleCnt;
        if (expectBeats) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + AW'(i) * s;
                sbQueue.push_back('{data: 64'(a) + 64'd100, last: (i == int'(n) - 1)});
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy || bus.m_valid || sbQueue.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: got busy=%0d expected idle", name, busy);
        end
        tick();
        tick();
    endtask

    // Monitor: scoreboard pop on handshake, done timing, stall stability, occupancy model.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            expDone   = 1'b0;
            prevStall = 1'b0;
            occ       = 0;
        end else begin
            if (done || expDone) checkOutput("done pulse", 64'(done), 64'(expDone));
            if (done) begin
                doneCount++;
                doneCycle = cycleCnt;
            end
            if (prevStall) begin
                checkOutput("stall valid", 64'(bus.m_valid), 64'd1);
                checkOutput("stall data", bus.m_data, prevData);
                checkOutput("stall last", 64'(bus.m_last), 64'(prevLast));
            end
            checkOutput("valid vs occupancy", 64'(bus.m_valid), 64'(occ != 0));
            if (occ == 2 && !bus.m_ready) checkOutput("rd_en while full", 64'(bus.buf_rd_en), 64'd0);
            expDone = 1'b0;
            if (bus.m_valid && bus.m_ready) begin
                beatCount++;
                if (firstBeatCycle < 0) firstBeatCycle = cycleCnt;
                if (sbQueue.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra beat: got %0d expected none", bus.m_data);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("beat data", bus.m_data, e.data);
                    checkOutput("beat last", 64'(bus.m_last), 64'(e.last));
                    expDone = e.last;
                end
            end
            if (zeroCmd) expDone = 1'b1;
            occ = occ + int'(bus.buf_rd_en) - int'(bus.m_valid && bus.m_ready);
            prevStall = bus.m_valid && !bus.m_ready;
            prevData  = bus.m_data;
            prevLast  = bus.m_last;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        for (int i = 0; i < 64; i++) mem[i] = 64'(i) + 64'd100;

        tick();
        tick();
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset valid", 64'(bus.m_valid), 64'd0);
        checkOutput("reset rd_en", 64'(bus.buf_rd_en), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] contiguous burst");
        firstBeatCycle = -1;
        d0 = doneCount;
        applyStimulus(6'd4, 6'd1, 7'd4, 1'b1);
        checkOutput("busy after accept", 64'(busy), 64'd1);
        waitIdle("contiguous");
        checkOutput("first beat latency", 64'(firstBeatCycle - startCycle), 64'd2);
        checkOutput("done latency", 64'(doneCycle - startCycle), 64'd6);
        checkOutput("contiguous done count", 64'(doneCount - d0), 64'd1);

        $display("[TB] wrapping stride");
        d0 = doneCount;
        applyStimulus(6'd60, 6'd3, 7'd4, 1'b1);
        waitIdle("wrap");
        checkOutput("wrap done count", 64'(doneCount - d0), 64'd1);

        $display("[TB] backpressure");
        d0 = doneCount;
        readyPhase   = 0;
        readyPattern = 1'b1;
        applyStimulus(6'd10, 6'd1, 7'd6, 1'b1);
        waitIdle("backpressure");
        readyPattern = 1'b0;
        tick();
        checkOutput("backpressure done count", 64'(doneCount - d0), 64'd1);

        $display("[TB] zero count and buffer not ready");
        zeroCmd = 1'b1;
        applyStimulus(6'd0, 6'd1, 7'd0, 1'b0);
        zeroCmd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("zero busy", 64'(busy), 64'd0);
            checkOutput("zero valid", 64'(bus.m_valid), 64'd0);
            checkOutput("zero rd_en", 64'(bus.buf_rd_en), 64'd0);
            tick();
        end
        d0 = doneCount;
        bufReady = 1'b0;
        applyStimulus(6'd0, 6'd1, 7'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("not ready busy", 64'(busy), 64'd0);
            checkOutput("not ready rd_en", 64'(bus.buf_rd_en), 64'd0);
            tick();
        end
        bufReady = 1'b1;
        checkOutput("not ready done count", 64'(doneCount - d0), 64'd0);

        $display("[TB] start while busy");
        d0 = doneCount;
        applyStimulus(6'd20, 6'd2, 7'd5, 1'b1);
        tick();
        tick();
        applyStimulus(6'd40, 6'd1, 7'd3, 1'b0);
        waitIdle("restart ignored");
        checkOutput("restart done count", 64'(doneCount - d0), 64'd1);

        $display("[TB] reset mid burst");
        d0 = doneCount;
        beatCount = 0;
        applyStimulus(6'd0, 6'd1, 7'd8, 1'b1);
        for (int i = 0; i < 50 && beatCount < 2; i++) tick();
        checkOutput("beats before reset", 64'(beatCount), 64'd2);
        rst = 1'b1;
        #1;
        checkOutput("rst busy", 64'(busy), 64'd0);
        checkOutput("rst done", 64'(done), 64'd0);
        checkOutput("rst rd_en", 64'(bus.buf_rd_en), 64'd0);
        checkOutput("rst rd_addr", 64'(bus.buf_rd_addr), 64'd0);
        checkOutput("rst valid", 64'(bus.m_valid), 64'd0);
        checkOutput("rst data", bus.m_data, 64'd0);
        checkOutput("rst last", 64'(bus.m_last), 64'd0);
        sbQueue.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("no done after reset", 64'(doneCount - d0), 64'd0);
        applyStimulus(6'd30, 6'd1, 7'd3, 1'b1);
        waitIdle("after reset");
        checkOutput("after reset done count", 64'(doneCount - d0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffer_stream_reader.md
Name: buffer_stream_reader

Overview:
- Read-side sequencer for the TensorCore operand buffer.
- Walks a strided address sequence through the buffer's read port (rd_en/rd_addr, combinational data_out) and streams the words to the MAC array over a valid/ready interface with a last-beat marker.
- One command per burst; a done pulse follows the final accepted beat.
- Sits between the operand buffer and the systolic/MAC datapath.

Parameters:
- DATA_WIDTH, 64, word width; matches the buffer.
- ADDR_WIDTH, 6, buffer address width. The buffer depth is 2**ADDR_WIDTH.
- CNT_WIDTH, 7, burst length width; allows up to 2**ADDR_WIDTH words.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled in IDLE only
- base_addr  input  ADDR_WIDTH  first read address
- stride  input  ADDR_WIDTH  address increment per word
- count  input  CNT_WIDTH  number of words in the burst
- busy  output  1  high from command acceptance until done
- done  output  1  one-cycle pulse at burst completion
- buf_ready  input  1  buffer "ready" flag (buffer has been written at least once)
- buf_rd_en  output  1  buffer read enable
- buf_rd_addr  output  ADDR_WIDTH  buffer read address
- buf_data  input  DATA_WIDTH  buffer data_out (same-cycle, combinational)
- m_valid  output  1  stream beat valid
- m_data  output  DATA_WIDTH  stream beat data
- m_last  output  1  marks the final beat of the burst
- m_ready  input  1  downstream accept

Behaviour:
- Reset: all outputs 0 (busy, done, buf_rd_en, buf_rd_addr, m_valid, m_data, m_last); FSM to IDLE; output FIFO emptied; counters cleared. Reset mid-burst aborts the burst with no done pulse.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - If start=1 and buf_ready=1 and count!=0: latch base_addr, stride, count; go to STREAM; busy=1 from the next cycle.
  - If start=1 and buf_ready=1 and count==0: done pulses in the next cycle; stay IDLE; busy stays 0.
  - If start=1 and buf_ready=0: ignored.
- start is ignored while busy; it is not queued.
- STREAM:
  - Issue a read when the FIFO occupancy is below 2, or when a pop (m_valid && m_ready) happens in the same cycle.
  - On issue: buf_rd_en=1, buf_rd_addr=current address, and buf_data is pushed into the FIFO at the next posedge.
  - After each issue: address += stride, modulo 2**ADDR_WIDTH (natural wrap); remaining count decrements.
  - The issue of the final word transitions the FSM to DRAIN.
  - When not issuing: buf_rd_en=0 and buf_rd_addr holds its last value.
- DRAIN: no reads. When the beat carrying m_last is accepted, done=1 for one cycle, busy=0 in that same cycle, and the FSM returns to IDLE.
- Output FIFO: 2 entries; each entry holds data plus a last flag. m_valid = FIFO not empty. m_data and m_last come from the head entry and are held stable while m_valid && !m_ready.
- Latency:
  - start accepted at edge T; first read issued in cycle T+1; m_valid high in cycle T+2.
  - With m_ready held high, throughput is 1 beat/cycle.
  - A burst of N words completes (done) in cycle T+N+2.
- Backpressure: with m_ready=0 the FIFO fills to 2 and reads stall; no beat is dropped or duplicated. Issue is combinationally gated by m_ready only through the pop term.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- count == 2**ADDR_WIDTH: every buffer location is read once when stride is odd. Other strides revisit addresses; this is permitted and is the caller's responsibility.

Decomposition:
- Shared package tc_buf_pkg:
  - FSM state encoding (IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2).
  - Default DATA_WIDTH and ADDR_WIDTH constants, shared with the buffer.
- Sub-module stream_fifo2: a 2-entry synchronous FIFO.
  - Ports: push, push_data, push_last, pop, count, head outputs.
  - Asynchronous reset to empty.
  - The reader instantiates one stream_fifo2.

Test Plan:
- Buffer preloaded with mem[i]=i+100; start with base=4, stride=1, count=4, m_ready=1 → beats 104,105,106,107 on consecutive cycles; m_last only on 107; done one cycle after the 107 handshake.
- base=60, stride=3, count=4 → addresses 60,63,2,5 (wrap); data 160,163,102,105.
- count=6, m_ready toggling 1,0,0,1,… → exactly 6 beats in order; m_data stable while stalled; buf_rd_en low whenever the FIFO is full and m_ready=0.
- start with count=0 → done pulses next cycle; busy, m_valid and buf_rd_en stay 0. start with buf_ready=0 → no response.
- Second start pulse mid-burst → ignored; original burst completes unchanged with a single done.
- rst asserted after the 2nd beat of an 8-beat burst → all outputs 0 immediately; no done pulse; a fresh start after rst release streams correctly from its own base.
